pbtn_event_arbiter: RTL and testbench

- Converts debounced pushbutton levels into discrete press and auto-repeat events.
- Arbitrates simultaneous events round-robin into a small event FIFO.
- Presents the events to one consumer (menu/robot command FSM) over a valid/ready handshake.
- Sits directly downstream of the pushbutton/switch debouncer; pb0 (CPU reset) is excluded.

---
 rtl/pbtn_event_arbiter_pkg.sv | 23 ++
 rtl/pbtn_event_arbiter_if.sv | 14 +
 rtl/pbtn_event_arbiter_evt_fifo.sv | 53 +++++
 rtl/pbtn_event_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_pbtn_event_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pbtn_event_arbiter_pkg.sv
// Shared types for the pushbutton event arbiter.
//   btn_state_t : per-button press/hold/repeat state
//   evt_t       : one queued event {button id, auto-repeat flag}
//   MS_TOP      : top count of the 1 ms tick divider
package pbtn_evt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // 'repeat' is a keyword, so the auto-repeat flag is called rpt.
    typedef struct packed {
        logic [2:0] id;
        logic       rpt;
    } evt_t;

    function automatic int MS_TOP(input int clk_hz, input int simulate, input int sim_cnt);
        return (simulate != 0) ? sim_cnt : (clk_hz / 1000) - 1;
    endfunction

endpackage

// File: rtl/pbtn_event_arbiter_if.sv
// Event handshake between the arbiter (master) and its single consumer (slave).
//   evt_valid  : head event present
//   evt_ready  : consumer takes the head event this cycle
//   evt_id     : button index of the head event
//   evt_repeat : head event is an auto-repeat
interface pbtn_event_arbiter_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_id;
    logic       evt_repeat;

    modport master (output evt_valid, output evt_id, output evt_repeat, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_repeat, output evt_ready);
endinterface

// File: rtl/pbtn_event_arbiter_evt_fifo.sv
// Synchronous first-word-fall-through FIFO of evt_t.
//   push/din   : write when not full (or when full and popping the same cycle)
//   pop        : drop the head entry; ignored when empty
//   dout       : head entry, valid whenever empty=0
//   empty/full : occupancy flags
module evt_fifo
    import pbtn_evt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  evt_t din,
    input  logic pop,
    output evt_t dout,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(DEPTH);

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pbtn_event_arbiter.sv
// Pushbutton event arbiter: turns debounced button levels into press and
// auto-repeat events, arbitrates them round-robin into an event FIFO and
// presents them to one consumer.
//   clk, reset   : clock, synchronous active-high reset
//   pbtn_db      : debounced button levels, bit i = button i
//   evt          : event handshake (master side)
//   evt_overflow : sticky, an event was coalesced away
//   pending      : per-button request latches
// Build option: PBTN_AUTOREPEAT_EN enables hold/auto-repeat events; without
// it only press events exist and evt_repeat is always 0.
module pbtn_event_arbiter
    import pbtn_evt_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ  = 100000000,
    parameter int NUM_BTNS          = 5,
    parameter int HOLD_DELAY_MS     = 500,
    parameter int REPEAT_MS         = 100,
    parameter int FIFO_DEPTH        = 4,
    parameter int CNTR_WIDTH        = 32,
    parameter int SIMULATE          = 0,
    parameter int SIMULATE_TICK_CNT = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BTNS-1:0]   pbtn_db,
    pbtn_event_arbiter_if.master  evt,
    output logic                  evt_overflow,
    output logic [NUM_BTNS-1:0]   pending
);
`ifdef PBTN_AUTOREPEAT_EN
    localparam logic REP_EN = 1'b1;
`else
    localparam logic REP_EN = 1'b0;
`endif

    logic [NUM_BTNS-1:0] pbtn_q, armed, rise;
    logic [NUM_BTNS-1:0] req_pls, req_rep;
    logic [NUM_BTNS-1:0] latch_req, latch_rep, gnt_vec;
    logic                gnt_vld, hi_vld, lo_vld, empty, full;
    logic [2:0]          gid, hi_id, lo_id, last_grant;
    evt_t                push_evt, head;

    // armed blocks a button that was already down when reset released:
    // it must be seen low once before a rising edge counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            pbtn_q <= '0;
            armed  <= '0;
        end else begin
            pbtn_q <= pbtn_db;
            armed  <= armed | ~pbtn_db;
        end
    end
    assign rise = pbtn_db & ~pbtn_q & armed;

`ifdef PBTN_AUTOREPEAT_EN
    localparam int TICK_TOP = MS_TOP(CLK_FREQUENCY_HZ, SIMULATE, SIMULATE_TICK_CNT);
    localparam int MS_MAX   = (HOLD_DELAY_MS > REPEAT_MS) ? HOLD_DELAY_MS : REPEAT_MS;
    localparam int MS_W     = (MS_MAX < 1) ? 1 : $clog2(MS_MAX + 1);

    logic [CNTR_WIDTH-1:0] div_cnt;
    logic                  tick;

    assign tick = (div_cnt == CNTR_WIDTH'(TICK_TOP));

    always_ff @(posedge clk) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_state_t      st;
        logic [MS_W-1:0] cnt;
        logic            req_p, req_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                st    <= IDLE;
                cnt   <= '0;
                req_p <= 1'b0;
                req_r <= 1'b0;
            end else begin
                req_p <= 1'b0;
                req_r <= 1'b0;
                if (!pbtn_db[i]) begin
                    st  <= IDLE;
                    cnt <= '0;
                end else begin
                    case (st)
                        IDLE: if (rise[i]) begin
                            st    <= HOLD;
                            cnt   <= '0;
                            req_p <= 1'b1;
                        end
                        HOLD: if (tick) begin
                            if (cnt == MS_W'(HOLD_DELAY_MS - 1)) begin
                                st    <= REPEAT;
                                cnt   <= '0;
                                req_p <= 1'b1;
                                req_r <= 1'b1;
                            end else cnt <= cnt + 1'b1;
                        end
                        REPEAT: if (tick) begin
                            if (cnt == MS_W'(REPEAT_MS - 1)) begin
                                cnt   <= '0;
                                req_p <= 1'b1;
                                req_r <= 1'b1;
                            end else cnt <= cnt + 1'b1;
                        end
                        default: st <= IDLE;
                    endcase
                end
            end
        end
        assign req_pls[i] = req_p;
        assign req_rep[i] = req_r;
    end
`else
    localparam int unused_cfg = MS_TOP(CLK_FREQUENCY_HZ, SIMULATE, SIMULATE_TICK_CNT)
                              + HOLD_DELAY_MS + REPEAT_MS + CNTR_WIDTH;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_state_t st;
        logic       req_p;

        always_ff @(posedge clk) begin
            if (reset) begin
                st    <= IDLE;
                req_p <= 1'b0;
            end else begin
                req_p <= 1'b0;
                if (!pbtn_db[i]) st <= IDLE;
                else if (st == IDLE && rise[i]) begin
                    st    <= HOLD;
                    req_p <= 1'b1;
                end
            end
        end
        assign req_pls[i] = req_p;
        assign req_rep[i] = 1'b0;
    end
`endif

    // Round-robin: first request above last_grant, else lowest request.
    always_comb begin
        hi_vld = 1'b0;
        hi_id  = '0;
        lo_vld = 1'b0;
        lo_id  = '0;
        for (int j = NUM_BTNS - 1; j >= 0; j--) begin
            if (latch_req[j]) begin
                lo_vld = 1'b1;
                lo_id  = 3'(j);
                if (3'(j) > last_grant) begin
                    hi_vld = 1'b1;
                    hi_id  = 3'(j);
                end
            end
        end
        gnt_vld = (hi_vld || lo_vld) && !full;
        gid     = hi_vld ? hi_id : lo_id;
    end

    always_comb begin
        gnt_vec = '0;
        for (int i = 0; i < NUM_BTNS; i++) gnt_vec[i] = gnt_vld && (gid == 3'(i));
    end

    assign push_evt = '{id: gid, rpt: |(latch_rep & gnt_vec)};

    // A request landing on a still-set, ungranted latch merges into it; the
    // earlier event is lost, so flag overflow. A request arriving with a grant
    // simply reloads the latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_req    <= '0;
            latch_rep    <= '0;
            evt_overflow <= 1'b0;
            last_grant   <= 3'(NUM_BTNS - 1);
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (req_pls[i]) begin
                    latch_req[i] <= 1'b1;
                    if (latch_req[i] && !gnt_vec[i]) begin
                        latch_rep[i] <= REP_EN;
                        evt_overflow <= 1'b1;
                    end else begin
                        latch_rep[i] <= req_rep[i];
                    end
                end else if (gnt_vec[i]) begin
                    latch_req[i] <= 1'b0;
                    latch_rep[i] <= 1'b0;
                end
            end
            if (gnt_vld) last_grant <= gid;
        end
    end

    evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (gnt_vld),
        .din   (push_evt),
        .pop   (!empty && evt.evt_ready),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    // FIFO storage is not reset, so gate the head fields with empty.
    assign evt.evt_valid  = !empty;
    assign evt.evt_id     = empty ? 3'd0 : head.id;
    assign evt.evt_repeat = !empty && head.rpt;
    assign pending        = latch_req;
endmodule

// File: tb/tb_pbtn_event_arbiter.sv
module tb_pbtn_event_arbiter;
`ifdef PBTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] pbtn = '0;
    logic       ovf;
    logic [4:0] pend;
    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;

    pbtn_event_arbiter_if evt_if ();

    pbtn_event_arbiter #(
        .CLK_FREQUENCY_HZ  (100000000),
        .NUM_BTNS          (5),
        .HOLD_DELAY_MS     (4),
        .REPEAT_MS         (2),
        .FIFO_DEPTH        (4),
        .CNTR_WIDTH        (32),
        .SIMULATE          (1),
        .SIMULATE_TICK_CNT (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pbtn_db      (pbtn),
        .evt          (evt_if),
        .evt_overflow (ovf),
        .pending      (pend)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    // Leaves the bench in cycle 0: the first cycle after reset releases.
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        pbtn = '0;
        evt_if.evt_ready = 1'b1;
        do_reset();
        if (evt_if.evt_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", evt_if.evt_valid); fails++; end
        checks++;
        if (evt_if.evt_id !== 3'd0) begin $display("FAIL reset_id got %0d want 0", evt_if.evt_id); fails++; end
        checks++;
        if (evt_if.evt_repeat !== 1'b0) begin $display("FAIL reset_repeat got %b want 0", evt_if.evt_repeat); fails++; end
        checks++;
        if (ovf !== 1'b0) begin $display("FAIL reset_overflow got %b want 0", ovf); fails++; end
        checks++;
        if (pend !== 5'b0) begin $display("FAIL reset_pending got %b want 00000", pend); fails++; end
        checks++;
    endtask

    task automatic test_single_press();
        do_reset();
        evt_if.evt_ready = 1'b1;
        for (int c = 5; c <= 20; c++) begin
            run_to(c);
            if (c == 5)  pbtn[2] = 1'b1;
            if (c == 15) pbtn[2] = 1'b0;
            if (evt_if.evt_valid !== (c == 8)) begin
                $display("FAIL single_valid cyc %0d got %b want %b", c, evt_if.evt_valid, (c == 8)); fails++;
            end
            checks++;
            if (c == 7) begin
                if (pend !== 5'b00100) begin $display("FAIL single_pending got %b want 00100", pend); fails++; end
                checks++;
            end
            if (c == 8) begin
                if (evt_if.evt_id !== 3'd2 || evt_if.evt_repeat !== 1'b0) begin
                    $display("FAIL single_evt got id %0d rep %b want id 2 rep 0", evt_if.evt_id, evt_if.evt_repeat); fails++;
                end
                checks++;
            end
        end
    endtask

    task automatic test_hold();
        logic exp_v;
        do_reset();
        evt_if.evt_ready = 1'b1;
        for (int c = 5; c <= 75; c++) begin
            run_to(c);
            if (c == 5)  pbtn[1] = 1'b1;
            if (c == 65) pbtn[1] = 1'b0;
            exp_v = (c == 8) || (AR && (c == 32 || c == 44 || c == 56));
            if (evt_if.evt_valid !== exp_v) begin
                $display("FAIL hold_valid cyc %0d got %b want %b", c, evt_if.evt_valid, exp_v); fails++;
            end
            checks++;
            if (exp_v) begin
                if (evt_if.evt_id !== 3'd1 || evt_if.evt_repeat !== (c != 8)) begin
                    $display("FAIL hold_evt cyc %0d got id %0d rep %b want id 1 rep %b",
                             c, evt_if.evt_id, evt_if.evt_repeat, (c != 8)); fails++;
                end
                checks++;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic       exp_v;
        logic [2:0] exp_id;
        do_reset();
        evt_if.evt_ready = 1'b1;
        for (int c = 5; c <= 22; c++) begin
            run_to(c);
            if (c == 5 || c == 14) pbtn = 5'b11001;
            if (c == 12 || c == 21) pbtn = 5'b00000;
            exp_v = 1'b1;
            case (c)
                8, 17:   exp_id = 3'd0;
                9, 18:   exp_id = 3'd3;
                10, 19:  exp_id = 3'd4;
                default: begin exp_id = 3'd0; exp_v = 1'b0; end
            endcase
            if (evt_if.evt_valid !== exp_v) begin
                $display("FAIL simul_valid cyc %0d got %b want %b", c, evt_if.evt_valid, exp_v); fails++;
            end
            checks++;
            if (exp_v) begin
                if (evt_if.evt_id !== exp_id) begin
                    $display("FAIL simul_id cyc %0d got %0d want %0d", c, evt_if.evt_id, exp_id); fails++;
                end
                checks++;
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        evt_if.evt_ready = 1'b0;
        for (int c = 5; c <= 20; c++) begin
            run_to(c);
            if (c == 5)  pbtn = 5'b11111;
            if (c == 18) pbtn = 5'b00000;
            if (c >= 11 && c <= 13) begin
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd0) begin
                    $display("FAIL bp_head cyc %0d got v %b id %0d want v 1 id 0", c, evt_if.evt_valid, evt_if.evt_id); fails++;
                end
                checks++;
                if (pend !== 5'b10000) begin $display("FAIL bp_pending cyc %0d got %b want 10000", c, pend); fails++; end
                checks++;
                if (ovf !== 1'b0) begin $display("FAIL bp_overflow cyc %0d got %b want 0", c, ovf); fails++; end
                checks++;
            end
            if (c >= 14 && c <= 17) begin
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'(c - 13)) begin
                    $display("FAIL bp_drain cyc %0d got v %b id %0d want v 1 id %0d", c, evt_if.evt_valid, evt_if.evt_id, c - 13); fails++;
                end
                checks++;
            end
            if (c == 15) begin
                if (pend !== 5'b00000) begin $display("FAIL bp_pending_clear got %b want 00000", pend); fails++; end
                checks++;
            end
            if (c >= 18) begin
                if (evt_if.evt_valid !== 1'b0) begin $display("FAIL bp_empty cyc %0d got %b want 0", c, evt_if.evt_valid); fails++; end
                checks++;
            end
            if (c == 13) evt_if.evt_ready = 1'b1;
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_id;
        do_reset();
        evt_if.evt_ready = 1'b0;
        for (int c = 5; c <= 40; c++) begin
            run_to(c);
            if (c == 12 || c == 32) begin
                if (ovf !== (c == 32)) begin $display("FAIL ovf_flag cyc %0d got %b want %b", c, ovf, (c == 32)); fails++; end
                checks++;
                if (pend !== 5'b00010) begin $display("FAIL ovf_pending cyc %0d got %b want 00010", c, pend); fails++; end
                checks++;
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd0) begin
                    $display("FAIL ovf_head cyc %0d got v %b id %0d want v 1 id 0", c, evt_if.evt_valid, evt_if.evt_id); fails++;
                end
                checks++;
            end
            if (c >= 33 && c <= 36) begin
                case (c)
                    33:      exp_id = 3'd2;
                    34:      exp_id = 3'd3;
                    35:      exp_id = 3'd4;
                    default: exp_id = 3'd1;
                endcase
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== exp_id || evt_if.evt_repeat !== (AR && c == 36)) begin
                    $display("FAIL ovf_drain cyc %0d got v %b id %0d rep %b want v 1 id %0d rep %b",
                             c, evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat, exp_id, (AR && c == 36)); fails++;
                end
                checks++;
            end
            if (c == 38 || c == 40) begin
                if (ovf !== 1'b1 || evt_if.evt_valid !== 1'b0 || pend !== 5'b0) begin
                    $display("FAIL ovf_sticky cyc %0d got ovf %b v %b pend %b want 1 0 00000", c, ovf, evt_if.evt_valid, pend); fails++;
                end
                checks++;
            end
            if (c == 5)  pbtn = 5'b11101;
            if (c == 7)  pbtn[1] = 1'b1;
            if (c == 9)  pbtn = 5'b00010;
            if (!AR && c == 12) pbtn[1] = 1'b0;
            if (!AR && c == 14) pbtn[1] = 1'b1;
            if (c == 32) evt_if.evt_ready = 1'b1;
            if (c == 37) pbtn[1] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        evt_if.evt_ready = 1'b1;
        run_to(5);
        pbtn[2] = 1'b1;
        run_to(36);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        if (evt_if.evt_valid !== 1'b0 || evt_if.evt_id !== 3'd0 || evt_if.evt_repeat !== 1'b0 || ovf !== 1'b0 || pend !== 5'b0) begin
            $display("FAIL rmh_outputs got v %b id %0d rep %b ovf %b pend %b want all 0",
                     evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat, ovf, pend); fails++;
        end
        checks++;
        for (int c = 1; c <= 46; c++) begin
            run_to(c);
            if (c == 40) pbtn[2] = 1'b0;
            if (c == 42) pbtn[2] = 1'b1;
            if (evt_if.evt_valid !== (c == 45)) begin
                $display("FAIL rmh_valid cyc %0d got %b want %b", c, evt_if.evt_valid, (c == 45)); fails++;
            end
            checks++;
            if (c == 45) begin
                if (evt_if.evt_id !== 3'd2 || evt_if.evt_repeat !== 1'b0) begin
                    $display("FAIL rmh_evt got id %0d rep %b want id 2 rep 0", evt_if.evt_id, evt_if.evt_repeat); fails++;
                end
                checks++;
            end
        end
        pbtn = '0;
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        test_reset();
        test_single_press();
        test_hold();
        test_simultaneous();
        test_back_pressure();
        test_overflow();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
